// File: rtl/led_p2s_pkg.sv
// Shared definitions for the LED parallel-to-serial shifter.
// Contents:
//   p2s_state_e - transfer FSM states (IDLE=0, SHIFT=1, LATCH=2)
//   cnt_w()     - counter width able to hold 0..n without wrapping
package led_p2s_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLatch = 2'd2
  } p2s_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/p2s_phase_tick.sv
// Half-period phase counter for serial drivers.
// Counts system-clock cycles while enabled and emits a one-cycle tick in the
// last cycle of every HALF-cycle half-period.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear; counter restarts at zero, no tick
//   en    - count enable
//   tick  - high in the final cycle of each half-period
module p2s_phase_tick
  import led_p2s_pkg::*;
#(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = cnt_w(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_p2s.sv
// Parallel-to-serial shifter for the external 74HC595-style LED register chain.
// Shifts par_data out MSB-first with a self-generated serial clock, then pulses
// the storage latch. All outputs are registered.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   start    - transfer request, sampled only while idle
//   par_data - word captured on the accepted start edge
//   busy     - high while a transfer is in progress
//   done     - one-cycle pulse in the first idle cycle after a transfer
//   sclk     - serial shift clock (HALF cycles low, HALF cycles high per bit)
//   sdata    - serial data, changes only at the start of a low phase
//   latch    - storage strobe, high for HALF cycles after the last bit
module led_p2s
  import led_p2s_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HALF   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              latch
);

  localparam int unsigned BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  p2s_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              hi_q, hi_d;  // current half of the bit: 0 = sclk low, 1 = sclk high
  logic              tick;
  logic              busy_d, done_d, sclk_d, sdata_d, latch_d;

  // Idle holds the counter cleared so every transfer starts on a fresh half-period.
  p2s_phase_tick #(
    .HALF(HALF)
  ) u_phase_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StIdle),
    .en   (state_q != StIdle),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          shift_d = par_data;
          bit_d   = '0;
          hi_d    = 1'b0;
        end
      end
      StShift: begin
        if (tick) begin
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            // End of the high phase: advance to the next bit.
            hi_d    = 1'b0;
            shift_d = shift_q << 1;
            bit_d   = bit_q + BW'(1);
            if (bit_q == LAST_BIT) begin
              state_d = StLatch;
            end
          end
        end
      end
      StLatch: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    busy_d  = (state_d != StIdle);
    done_d  = (state_q == StLatch) && (state_d == StIdle);
    sclk_d  = (state_d == StShift) && hi_d;
    sdata_d = (state_d == StShift) && shift_d[DATA_W-1];
    latch_d = (state_d == StLatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sclk  <= 1'b0;
      sdata <= 1'b0;
      latch <= 1'b0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      sclk  <= sclk_d;
      sdata <= sdata_d;
      latch <= latch_d;
    end
  end

endmodule

// File: tb/tb_led_p2s.sv
module tb_led_p2s;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 2;
  localparam int unsigned W2   = 16;
  localparam int unsigned H2   = 1;
  localparam int unsigned LEN  = 2 * H * W + H;
  localparam int unsigned LEN2 = 2 * H2 * W2 + H2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  par_data = '0;
  logic          busy, done, sclk, sdata, latch;
  logic          start2 = 1'b0;
  logic [W2-1:0] par_data2 = '0;
  logic          busy2, done2, sclk2, sdata2, latch2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  led_p2s #(.DATA_W(W), .HALF(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .par_data(par_data),
    .busy(busy), .done(done), .sclk(sclk), .sdata(sdata), .latch(latch)
  );

  led_p2s #(.DATA_W(W2), .HALF(H2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .par_data(par_data2),
    .busy(busy2), .done(done2), .sclk(sclk2), .sdata(sdata2), .latch(latch2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers: what an external 74HC595 would see, sampled mid-cycle.
  logic bits_a[$];
  int   done_at[$];
  int   busy_a = 0, latch_a = 0, done_a = 0, stab_a = 0;
  logic psclk_a = 1'b0, psdata_a = 1'b0, pbusy_a = 1'b0;
  always @(negedge clk) begin
    if (busy) busy_a++;
    if (latch) latch_a++;
    if (done) begin
      done_a++;
      done_at.push_back(cyc);
    end
    if (sclk && !psclk_a) bits_a.push_back(sdata);
    // sdata may only move where sclk falls
    if (pbusy_a && busy && (sdata !== psdata_a) && !(psclk_a && !sclk)) stab_a++;
    psclk_a  = sclk;
    psdata_a = sdata;
    pbusy_a  = busy;
  end

  logic bits_b[$];
  int   busy_b = 0, done_b = 0;
  logic psclk_b = 1'b0;
  always @(negedge clk) begin
    if (busy2) busy_b++;
    if (done2) done_b++;
    if (sclk2 && !psclk_b) bits_b.push_back(sdata2);
    psclk_b = sclk2;
  end

  function automatic logic [31:0] pack_a(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 1) | 32'(bits_a[base+i]);
    return v;
  endfunction

  function automatic logic [31:0] pack_b(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 1) | 32'(bits_b[base+i]);
    return v;
  endfunction

  task automatic pulse_a(input logic [W-1:0] w);
    @(posedge clk); #1;
    par_data = w;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    par_data = W'($urandom);
  endtask

  task automatic wait_done_a(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b1;
    start2   = 1'b1;
    par_data = W'($urandom);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sclk, sdata, latch} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, sclk, sdata, latch});
    end
    checks++;
    if ({busy2, done2, sclk2, sdata2, latch2} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs_wide: got %b want 00000",
               {busy2, done2, sclk2, sdata2, latch2});
    end
    start  = 1'b0;
    start2 = 1'b0;
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sclk, sdata, latch} !== 5'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got %b want 00000", {busy, done, sclk, sdata, latch});
    end
  endtask

  task automatic test_single();
    int b0 = bits_a.size(), bu0 = busy_a, l0 = latch_a, d0 = done_a, s0 = stab_a;
    bit seen;
    pulse_a(8'hA5);
    wait_done_a(100, seen);
    repeat (3) @(negedge clk);
    checks++;
    if (!seen) begin failures++; $display("FAIL single_done: got none want pulse"); end
    checks++;
    if (bits_a.size() - b0 != W) begin
      failures++;
      $display("FAIL single_edges: got %0d want %0d", bits_a.size() - b0, W);
    end else begin
      checks++;
      if (pack_a(b0, W) !== 32'hA5) begin
        failures++;
        $display("FAIL single_word: got %h want a5", pack_a(b0, W));
      end
    end
    checks++;
    if (busy_a - bu0 != 34) begin
      failures++;
      $display("FAIL single_busy_len: got %0d want 34", busy_a - bu0);
    end
    checks++;
    if (latch_a - l0 != H) begin
      failures++;
      $display("FAIL single_latch_len: got %0d want %0d", latch_a - l0, H);
    end
    checks++;
    if (done_a - d0 != 1) begin
      failures++;
      $display("FAIL single_done_count: got %0d want 1", done_a - d0);
    end
    checks++;
    if (stab_a != s0) begin
      failures++;
      $display("FAIL single_sdata_stable: got %0d bad moves want 0", stab_a - s0);
    end
  endtask

  task automatic test_busy_ignore();
    int b0 = bits_a.size(), bu0 = busy_a, d0 = done_a;
    bit seen;
    pulse_a(8'h0F);
    repeat (8) @(posedge clk);
    #1;
    par_data = 8'hFF;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done_a(100, seen);
    repeat (LEN + 5) @(negedge clk);
    checks++;
    if (done_a - d0 != 1) begin
      failures++;
      $display("FAIL ignore_done_count: got %0d want 1", done_a - d0);
    end
    checks++;
    if (bits_a.size() - b0 != W || pack_a(b0, W) !== 32'h0F) begin
      failures++;
      $display("FAIL ignore_word: got %0d bits %h want 8 bits 0f",
               bits_a.size() - b0, pack_a(b0, bits_a.size() - b0));
    end
    checks++;
    if (busy_a - bu0 != LEN) begin
      failures++;
      $display("FAIL ignore_busy_len: got %0d want %0d", busy_a - bu0, LEN);
    end
  endtask

  task automatic test_back_to_back();
    int b0 = bits_a.size(), bu0 = busy_a, d0 = done_a, t0 = done_at.size();
    bit seen1, seen2, rose;
    @(posedge clk); #1;
    par_data = 8'h81;
    start    = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin rose = 1'b1; break; end
    end
    par_data = 8'h7E;
    checks++;
    if (!rose) begin failures++; $display("FAIL b2b_start: got idle want busy"); end
    wait_done_a(100, seen1);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b want 1", busy);
    end
    wait_done_a(100, seen2);
    repeat (3) @(negedge clk);
    checks++;
    if (done_a - d0 != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d want 2", done_a - d0);
    end else begin
      checks++;
      if (done_at[t0+1] - done_at[t0] != int'(LEN) + 1) begin
        failures++;
        $display("FAIL b2b_done_spacing: got %0d want %0d",
                 done_at[t0+1] - done_at[t0], LEN + 1);
      end
    end
    checks++;
    if (bits_a.size() - b0 != 2 * W || pack_a(b0, 2 * W) !== 32'h817E) begin
      failures++;
      $display("FAIL b2b_words: got %0d bits %h want 16 bits 817e",
               bits_a.size() - b0, pack_a(b0, bits_a.size() - b0));
    end
    checks++;
    if (busy_a - bu0 != 2 * LEN) begin
      failures++;
      $display("FAIL b2b_busy_len: got %0d want %0d", busy_a - bu0, 2 * LEN);
    end
  endtask

  task automatic test_mid_reset();
    int b0 = bits_a.size(), l0 = latch_a, d0 = done_a;
    int b1, bu1;
    logic [W-1:0] w;
    bit seen;
    pulse_a(8'h3C);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bits_a.size() - b0 >= 3) break;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sclk, sdata, latch} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_async: got %b want 00000", {busy, done, sclk, sdata, latch});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LEN + 10) @(negedge clk);
    checks++;
    if (latch_a != l0 || done_a != d0) begin
      failures++;
      $display("FAIL midreset_no_latch: got latch=%0d done=%0d want 0 0",
               latch_a - l0, done_a - d0);
    end
    w   = W'($urandom);
    b1  = bits_a.size();
    bu1 = busy_a;
    pulse_a(w);
    wait_done_a(100, seen);
    repeat (3) @(negedge clk);
    checks++;
    if (bits_a.size() - b1 != W || pack_a(b1, W) !== 32'(w)) begin
      failures++;
      $display("FAIL midreset_fresh_word: got %0d bits %h want 8 bits %h",
               bits_a.size() - b1, pack_a(b1, bits_a.size() - b1), w);
    end
    checks++;
    if (busy_a - bu1 != LEN) begin
      failures++;
      $display("FAIL midreset_fresh_busy: got %0d want %0d", busy_a - bu1, LEN);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] w = W'($urandom);
      int b0 = bits_a.size(), bu0 = busy_a, d0 = done_a, l0 = latch_a;
      bit seen;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      pulse_a(w);
      wait_done_a(100, seen);
      repeat (3) @(negedge clk);
      checks++;
      if (bits_a.size() - b0 != W || pack_a(b0, W) !== 32'(w)) begin
        failures++;
        $display("FAIL random_word[%0d]: got %0d bits %h want 8 bits %h", n,
                 bits_a.size() - b0, pack_a(b0, bits_a.size() - b0), w);
      end
      checks++;
      if (busy_a - bu0 != LEN || done_a - d0 != 1 || latch_a - l0 != H) begin
        failures++;
        $display("FAIL random_timing[%0d]: got busy=%0d done=%0d latch=%0d want %0d 1 %0d",
                 n, busy_a - bu0, done_a - d0, latch_a - l0, LEN, H);
      end
    end
  endtask

  task automatic test_wide();
    logic [W2-1:0] words[2];
    words[0] = 16'h8001;
    words[1] = W2'($urandom);
    for (int n = 0; n < 2; n++) begin
      int  b0 = bits_b.size(), bu0 = busy_b, d0 = done_b;
      bit  seen = 1'b0;
      @(posedge clk); #1;
      par_data2 = words[n];
      start2    = 1'b1;
      @(posedge clk); #1;
      start2    = 1'b0;
      par_data2 = W2'($urandom);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done2) begin seen = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!seen || done_b - d0 != 1) begin
        failures++;
        $display("FAIL wide_done[%0d]: got %0d pulses want 1", n, done_b - d0);
      end
      checks++;
      if (busy_b - bu0 != LEN2) begin
        failures++;
        $display("FAIL wide_busy_len[%0d]: got %0d want %0d", n, busy_b - bu0, LEN2);
      end
      checks++;
      if (bits_b.size() - b0 != W2 || pack_b(b0, W2) !== 32'(words[n])) begin
        failures++;
        $display("FAIL wide_word[%0d]: got %0d bits %h want 16 bits %h", n,
                 bits_b.size() - b0, pack_b(b0, bits_b.size() - b0), words[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
